// File: rtl/led_seq_pkg.sv
// ----------------------------------------------------------------------------
// led_seq_pkg
// Shared constants for the LED sequencer:
//   MODO_*  : step-mode encodings seen on the modo input
//   phase_t : hold-filter phase (waiting for first step / auto-repeating)
// ----------------------------------------------------------------------------
package led_seq_pkg;

    localparam logic [1:0] MODO_FRENTE = 2'b00;  // forward, wraps at the top
    localparam logic [1:0] MODO_TRAS   = 2'b01;  // reverse, wraps at zero
    localparam logic [1:0] MODO_VAIVEM = 2'b10;  // ping-pong, bounces at ends
    localparam logic [1:0] MODO_PARADO = 2'b11;  // frozen, ticks are swallowed

    typedef enum logic {
        FIRST  = 1'b0,
        REPEAT = 1'b1
    } phase_t;

endpackage

// File: rtl/button_repeat.sv
// ----------------------------------------------------------------------------
// button_repeat
// Hold filter for an active-low push-button. The raw button is synchronised
// by two flops, then a hold counter counts consecutive low samples. The first
// tick fires after HOLD_CYCLES low samples; while the button stays held,
// further ticks fire every REPEAT_CYCLES low samples. Any high sample clears
// the count and rearms the FIRST phase.
//
// Ports:
//   clock  in  system clock
//   reset  in  synchronous active-high reset
//   botao  in  raw push-button, active-low, asynchronous
//   o_tick out one-cycle step request (combinational, valid on the edge
//              where the threshold is reached)
// ----------------------------------------------------------------------------
module button_repeat
    import led_seq_pkg::*;
#(
    parameter int HOLD_CYCLES   = 15000000,
    parameter int REPEAT_CYCLES = 15000000
) (
    input  logic clock,
    input  logic reset,
    input  logic botao,
    output logic o_tick
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    // Thresholds are compared against the count before the increment, so the
    // tick lines up with the edge on which the count would reach the target.
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    phase_t        r_phase;

    logic          w_btn_low;
    logic [CW-1:0] w_last;

    assign w_btn_low = ~r_sync[1];
    assign w_last    = (r_phase == FIRST) ? HOLD_LAST : REPEAT_LAST;
    assign o_tick    = w_btn_low && (r_cnt == w_last);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_phase <= FIRST;
        end else begin
            r_sync <= {r_sync[0], botao};
            if (!w_btn_low) begin
                r_cnt   <= '0;
                r_phase <= FIRST;
            end else if (o_tick) begin
                r_cnt   <= '0;
                r_phase <= REPEAT;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// ----------------------------------------------------------------------------
// led_sequencer
// One-hot LED bar sequencer stepped by a held push-button. button_repeat
// turns the button into step ticks; this level applies the step according to
// modo (sampled only on a tick) and keeps position, direction and the
// registered one-hot LED vector.
//
// Ports:
//   clock   in  system clock
//   reset   in  synchronous active-high reset
//   botao   in  push-button, active-low, asynchronous
//   modo    in  00 forward, 01 reverse, 10 ping-pong, 11 freeze
//   leds    out one-hot LED vector, equals 1 << posicao
//   posicao out binary index of the lit LED
//   passo   out one-cycle pulse after each position change
// ----------------------------------------------------------------------------
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter  int N_LEDS        = 4,
    parameter  int HOLD_CYCLES   = 15000000,
    parameter  int REPEAT_CYCLES = 15000000,
    localparam int PW            = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              botao,
    input  logic [1:0]        modo,
    output logic [N_LEDS-1:0] leds,
    output logic [PW-1:0]     posicao,
    output logic              passo
);

    localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);

    logic              r_dir;      // 0 = moving up, 1 = moving down
    logic [PW-1:0]     r_pos;
    logic [N_LEDS-1:0] r_leds;
    logic              r_passo;

    logic              w_tick;
    logic              w_dir_nxt;
    logic [PW-1:0]     w_pos_nxt;
    logic [N_LEDS-1:0] w_leds_nxt;

    button_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_button_repeat (
        .clock  (clock),
        .reset  (reset),
        .botao  (botao),
        .o_tick (w_tick)
    );

    always_comb begin
        w_pos_nxt = r_pos;
        w_dir_nxt = r_dir;
        case (modo)
            MODO_FRENTE: begin
                w_dir_nxt = 1'b0;
                w_pos_nxt = (r_pos == LAST) ? '0 : r_pos + 1'b1;
            end
            MODO_TRAS: begin
                w_dir_nxt = 1'b1;
                w_pos_nxt = (r_pos == '0) ? LAST : r_pos - 1'b1;
            end
            MODO_VAIVEM: begin
                // A single LED has no end to bounce off, so dir stays put.
                if (N_LEDS > 1) begin
                    if (!r_dir) begin
                        if (r_pos == LAST) begin
                            w_dir_nxt = 1'b1;
                            w_pos_nxt = r_pos - 1'b1;
                        end else begin
                            w_pos_nxt = r_pos + 1'b1;
                        end
                    end else begin
                        if (r_pos == '0) begin
                            w_dir_nxt = 1'b0;
                            w_pos_nxt = r_pos + 1'b1;
                        end else begin
                            w_pos_nxt = r_pos - 1'b1;
                        end
                    end
                end
            end
            default: ;  // MODO_PARADO: tick consumed, nothing moves
        endcase
    end

    always_comb begin
        w_leds_nxt = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            w_leds_nxt[i] = (w_pos_nxt == PW'(i));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pos     <= '0;
            r_dir     <= 1'b0;
            r_leds    <= '0;
            r_leds[0] <= 1'b1;
            r_passo   <= 1'b0;
        end else begin
            // passo only when the position really moves (not in freeze, and
            // never with a single LED).
            r_passo <= w_tick && (w_pos_nxt != r_pos);
            if (w_tick) begin
                r_pos  <= w_pos_nxt;
                r_dir  <= w_dir_nxt;
                r_leds <= w_leds_nxt;
            end
        end
    end

    assign leds    = r_leds;
    assign posicao = r_pos;
    assign passo   = r_passo;

endmodule
